// File: rtl/crc32_pkg.sv
// Shared constants and byte-level helpers for the IEEE 802.3 CRC-32 datapath.
// The register is kept in MSB-first form; wire bytes are LSB-first, hence the bit reversals.
package crc32_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam int          NB_W        = 4;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
    logic [31:0] c;
    c = crc ^ {bitrev8(data_byte), 24'h000000};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[31] ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Complemented register with each byte flipped back to wire order; first FCS byte lands in [31:24].
  function automatic logic [31:0] crc32_fcs(input logic [31:0] crc);
    logic [31:0] c;
    c = ~crc;
    return {bitrev8(c[31:24]), bitrev8(c[23:16]), bitrev8(c[15:8]), bitrev8(c[7:0])};
  endfunction

endpackage

// File: rtl/crc32_comb.sv
// Combinational CRC-32 update over the first nbytes bytes of a beat (first wire byte in the MSBs).
module crc32_comb
  import crc32_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [NB_W-1:0]         nbytes,
  output logic [31:0]             crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i < 32'(nbytes)) begin
        crc_out = crc32_byte(crc_out, data[8*(DATA_BYTES-1-i) +: 8]);
      end
    end
  end

endmodule

// File: rtl/crc32_fcs_engine.sv
// Ethernet FCS generate/check engine: frame-tracking FSM, optional input register stage,
// saturating length counter and held result outputs.
module crc32_fcs_engine
  import crc32_pkg::*;
#(
  parameter int  DATA_BYTES = 4,
  parameter int  PIPE       = 0,
  localparam int MW         = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic                    s_sop,
  input  logic                    s_eop,
  input  logic [MW-1:0]           s_mod,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic                    s_check,
  output logic                    crc_valid,
  output logic [31:0]             crc_o,
  output logic                    crc_ok,
  output logic [15:0]             len_o,
  output logic                    err_o
);

  logic                    b_valid, b_sop, b_eop, b_check;
  logic [MW-1:0]           b_mod;
  logic [8*DATA_BYTES-1:0] b_data;

  if (PIPE != 0) begin : g_pipe
    logic                    p_valid_q, p_valid_d, p_sop_q, p_sop_d;
    logic                    p_eop_q, p_eop_d, p_check_q, p_check_d;
    logic [MW-1:0]           p_mod_q, p_mod_d;
    logic [8*DATA_BYTES-1:0] p_data_q, p_data_d;

    // Framing bits are qualified by valid; the payload only loads on valid beats.
    always_comb begin
      p_valid_d = s_valid;
      p_sop_d   = s_valid & s_sop;
      p_eop_d   = s_valid & s_eop;
      p_check_d = s_valid ? s_check : p_check_q;
      p_mod_d   = s_valid ? s_mod : p_mod_q;
      p_data_d  = s_valid ? s_data : p_data_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        p_valid_q <= 1'b0;
        p_sop_q   <= 1'b0;
        p_eop_q   <= 1'b0;
        p_check_q <= 1'b0;
        p_mod_q   <= '0;
        p_data_q  <= '0;
      end else begin
        p_valid_q <= p_valid_d;
        p_sop_q   <= p_sop_d;
        p_eop_q   <= p_eop_d;
        p_check_q <= p_check_d;
        p_mod_q   <= p_mod_d;
        p_data_q  <= p_data_d;
      end
    end

    assign b_valid = p_valid_q;
    assign b_sop   = p_sop_q;
    assign b_eop   = p_eop_q;
    assign b_check = p_check_q;
    assign b_mod   = p_mod_q;
    assign b_data  = p_data_q;
  end else begin : g_nopipe
    assign b_valid = s_valid;
    assign b_sop   = s_sop;
    assign b_eop   = s_eop;
    assign b_check = s_check;
    assign b_mod   = s_mod;
    assign b_data  = s_data;
  end

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        mode_q, mode_d;
  logic        crc_valid_q, crc_valid_d;
  logic [31:0] crc_o_q, crc_o_d;
  logic        crc_ok_q, crc_ok_d;
  logic [15:0] len_o_q, len_o_d;
  logic        err_q, err_d;

  logic [NB_W-1:0] nbytes;
  logic [31:0]     crc_seed, crc_next;
  logic [16:0]     len_sum;
  logic [15:0]     len_next;
  logic            mode_eff;

  // A sop beat always restarts from init, so the sop path never looks at the running register.
  always_comb begin
    nbytes = NB_W'(DATA_BYTES);
    if (b_eop && (b_mod != '0)) begin
      nbytes = NB_W'(b_mod);
    end
    crc_seed = b_sop ? CRC_INIT : crc_q;
    len_sum  = (b_sop ? 17'd0 : {1'b0, len_q}) + 17'(nbytes);
    len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    mode_eff = b_sop ? b_check : mode_q;
  end

  crc32_comb #(.DATA_BYTES(DATA_BYTES)) u_comb (
    .crc_in (crc_seed),
    .data   (b_data),
    .nbytes (nbytes),
    .crc_out(crc_next)
  );

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    mode_d      = mode_q;
    crc_valid_d = 1'b0;
    crc_o_d     = crc_o_q;
    crc_ok_d    = crc_ok_q;
    len_o_d     = len_o_q;
    err_d       = 1'b0;
    if (b_valid) begin
      if (b_sop || (state_q == ST_FRAME)) begin
        err_d  = b_sop && (state_q == ST_FRAME);
        mode_d = mode_eff;
        crc_d  = crc_next;
        len_d  = len_next;
        if (b_eop) begin
          state_d     = ST_IDLE;
          crc_valid_d = 1'b1;
          crc_o_d     = crc32_fcs(crc_next);
          crc_ok_d    = mode_eff && (crc_next == CRC_RESIDUE);
          len_o_d     = len_next;
        end else begin
          state_d = ST_FRAME;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      mode_q      <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_o_q     <= '0;
      crc_ok_q    <= 1'b0;
      len_o_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      crc_valid_q <= crc_valid_d;
      crc_o_q     <= crc_o_d;
      crc_ok_q    <= crc_ok_d;
      len_o_q     <= len_o_d;
      err_q       <= err_d;
    end
  end

  assign crc_valid = crc_valid_q;
  assign crc_o     = crc_o_q;
  assign crc_ok    = crc_ok_q;
  assign len_o     = len_o_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_crc32_fcs_engine.sv
// Scoreboard bench: eight engine instances (1/2/4/8 bytes x PIPE 0/1) driven with random and known
// frames; expectations come from a byte-serial reflected CRC-32 model.
module tb_crc32_fcs_engine;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] len;
    int          cyc;
  } exp_t;

  localparam int NCFG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Classic LSB-first CRC-32 state over a byte stream.
  function automatic logic [31:0] ref_state(input bq_t b);
    logic [31:0] p;
    logic [31:0] r;
    p = reflect32(32'h04C11DB7);
    r = 32'hFFFFFFFF;
    foreach (b[i]) begin
      r = r ^ {24'h0, b[i]};
      repeat (8) r = r[0] ? ((r >> 1) ^ p) : (r >> 1);
    end
    return r;
  endfunction

  // FCS bytes go out least significant byte of the standard CRC value first.
  function automatic logic [31:0] ref_fcs(input logic [31:0] r);
    logic [31:0] c;
    c = ~r;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction

  function automatic bq_t mk_rand(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int DB  = (gi < 2) ? 4 : (gi < 4) ? 1 : (gi < 6) ? 2 : 8;
    localparam int PP  = gi % 2;
    localparam int MW  = (DB > 1) ? $clog2(DB) : 1;
    localparam int LAT = 1 + PP;

    logic            rst_n, s_valid, s_sop, s_eop, s_check;
    logic [MW-1:0]   s_mod;
    logic [8*DB-1:0] s_data;
    logic            crc_valid, crc_ok, err_o;
    logic [31:0]     crc_o;
    logic [15:0]     len_o;

    exp_t  res_q[$];
    int    err_q[$];
    bit    in_frame;
    string tag;
    exp_t  em;
    int    ec;

    crc32_fcs_engine #(.DATA_BYTES(DB), .PIPE(PP)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_sop    (s_sop),
      .s_eop    (s_eop),
      .s_mod    (s_mod),
      .s_data   (s_data),
      .s_check  (s_check),
      .crc_valid(crc_valid),
      .crc_o    (crc_o),
      .crc_ok   (crc_ok),
      .len_o    (len_o),
      .err_o    (err_o)
    );

    function automatic logic [8*DB-1:0] rnd_data();
      return (8*DB)'({$urandom, $urandom});
    endfunction

    task automatic idle(input int n);
      repeat (n) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_sop   = 1'($urandom);
        s_eop   = 1'($urandom);
        s_check = 1'($urandom);
        s_mod   = MW'($urandom);
        s_data  = rnd_data();
      end
    endtask

    task automatic drive_beat(input bit sop, input bit eop, input logic [MW-1:0] m,
                              input logic [8*DB-1:0] d, input bit ck, output int c);
      @(negedge clk);
      s_valid = 1'b1;
      s_sop   = sop;
      s_eop   = eop;
      s_mod   = m;
      s_data  = d;
      s_check = ck;
      c       = cyc;
    endtask

    task automatic send_frame(input bq_t b, input bit chk_mode, input int abort_at, input int gapmax,
                              input bit use_want, input logic [31:0] want);
      int nb, nbeats, c, idx;
      logic [8*DB-1:0] d;
      logic [MW-1:0] m;
      logic [31:0] r;
      bit last;
      exp_t e;
      nb     = b.size();
      nbeats = (nb + DB - 1) / DB;
      for (int k = 0; k < nbeats; k++) begin
        if (abort_at > 0 && k == abort_at) return;
        if (k > 0 && gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
        for (int j = 0; j < DB; j++) begin
          idx = k * DB + j;
          d[8*(DB-1-j) +: 8] = (idx < nb) ? b[idx] : 8'($urandom);
        end
        last = (k == nbeats - 1);
        m = last ? MW'((nb - k * DB) % DB) : MW'($urandom);
        drive_beat(k == 0, last, m, d, (k == 0) ? chk_mode : 1'($urandom), c);
        if (k == 0 && in_frame) err_q.push_back(c + LAT);
        in_frame = !last;
        if (last) begin
          r     = ref_state(b);
          e.crc = use_want ? want : ref_fcs(r);
          e.ok  = chk_mode && (r == reflect32(32'hC704DD7B));
          e.len = (nb > 65535) ? 16'hFFFF : 16'(nb);
          e.cyc = c + LAT;
          res_q.push_back(e);
        end
      end
    endtask

    task automatic stray();
      int c;
      drive_beat(1'b0, 1'($urandom), MW'($urandom), rnd_data(), 1'($urandom), c);
      err_q.push_back(c + LAT);
    endtask

    task automatic check_reset(input string what);
      chk({tag, " ", what, " crc_valid"}, 64'(crc_valid), 64'(0));
      chk({tag, " ", what, " crc_o"},     64'(crc_o),     64'(0));
      chk({tag, " ", what, " crc_ok"},    64'(crc_ok),    64'(0));
      chk({tag, " ", what, " len_o"},     64'(len_o),     64'(0));
      chk({tag, " ", what, " err_o"},     64'(err_o),     64'(0));
    endtask

    always @(negedge clk) begin
      if (crc_valid === 1'b1) begin
        if (res_q.size() == 0) begin
          chk({tag, " unexpected crc_valid"}, 64'(crc_valid), 64'(0));
        end else begin
          em = res_q.pop_front();
          chk({tag, " crc_o"},   64'(crc_o),  64'(em.crc));
          chk({tag, " crc_ok"},  64'(crc_ok), 64'(em.ok));
          chk({tag, " len_o"},   64'(len_o),  64'(em.len));
          chk({tag, " latency"}, 64'(cyc),    64'(em.cyc));
        end
      end else begin
        if (crc_valid !== 1'b0) chk({tag, " crc_valid known"}, 64'(crc_valid), 64'(0));
        if (res_q.size() > 0 && cyc > res_q[0].cyc) begin
          chk({tag, " missing crc_valid"}, 64'(crc_valid), 64'(1));
          void'(res_q.pop_front());
        end
      end
      if (err_o === 1'b1) begin
        if (err_q.size() == 0) begin
          chk({tag, " unexpected err_o"}, 64'(err_o), 64'(0));
        end else begin
          ec = err_q.pop_front();
          chk({tag, " err latency"}, 64'(cyc), 64'(ec));
        end
      end else begin
        if (err_o !== 1'b0) chk({tag, " err_o known"}, 64'(err_o), 64'(0));
        if (err_q.size() > 0 && cyc > err_q[0]) begin
          chk({tag, " missing err_o"}, 64'(err_o), 64'(1));
          void'(err_q.pop_front());
        end
      end
    end

    initial begin
      bq_t kv, b;
      logic [31:0] r;
      int idx;
      tag      = $sformatf("cfg%0d(DB=%0d,PIPE=%0d)", gi, DB, PP);
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_sop    = 1'b0;
      s_eop    = 1'b0;
      s_check  = 1'b0;
      s_mod    = '0;
      s_data   = '0;
      in_frame = 1'b0;
      kv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset("after reset");

      send_frame(kv, 1'b0, 0, 0, 1'b1, 32'h2639F4CB);
      b = kv;
      b.push_back(8'h26); b.push_back(8'h39); b.push_back(8'hF4); b.push_back(8'hCB);
      send_frame(b, 1'b1, 0, 1, 1'b0, '0);
      b[3] = b[3] ^ 8'h04;
      send_frame(b, 1'b1, 0, 1, 1'b0, '0);

      idle(2);
      stray();
      idle(1);
      send_frame(mk_rand(3 * DB), 1'b0, 2, 1, 1'b0, '0);
      send_frame(kv, 1'b0, 0, 1, 1'b1, 32'h2639F4CB);

      idle(6);
      send_frame(mk_rand(3 * DB), 1'b0, 2, 0, 1'b0, '0);
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      in_frame = 1'b0;
      check_reset("mid-frame reset");
      send_frame(kv, 1'b0, 0, 0, 1'b1, 32'h2639F4CB);

      for (int f = 0; f < 16; f++) send_frame(mk_rand(DB), 1'($urandom), 0, 0, 1'b0, '0);

      for (int f = 0; f < 40; f++) begin
        b = mk_rand(int'($urandom_range(40, 1)));
        if ($urandom_range(1, 0) == 1) begin
          r = ~ref_state(b);
          b.push_back(r[7:0]); b.push_back(r[15:8]); b.push_back(r[23:16]); b.push_back(r[31:24]);
          if ($urandom_range(2, 0) == 0) begin
            idx = int'($urandom_range(b.size() - 1, 0));
            b[idx] = b[idx] ^ 8'(1 << $urandom_range(7, 0));
          end
          send_frame(b, 1'b1, 0, 2, 1'b0, '0);
        end else begin
          send_frame(b, 1'b0, 0, 2, 1'b0, '0);
        end
        idle(int'($urandom_range(2, 0)));
      end

      if (DB >= 4) send_frame(mk_rand(65600), 1'b0, 0, 0, 1'b0, '0);

      idle(8);
      chk({tag, " pending results"}, 64'(res_q.size()), 64'(0));
      chk({tag, " pending errors"},  64'(err_q.size()), 64'(0));
      n_done++;
    end
  end

  initial begin
    while (n_done < NCFG && cyc < 60000) @(posedge clk);
    if (n_done < NCFG) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: finished=%0d required=%0d", n_done, NCFG);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
